// File: rtl/udiv_pkg.sv
// rtl/udiv_pkg.sv - shared types and constants for the unsigned sequential divider
//   Contents: udiv_state_t (IDLE, DIV, DONE), DEFAULT_WIDTH, CNT_W, cnt_width()
//   Optional feature macro used by the divider: UDIV_EARLY_OUT_EN
package udiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } udiv_state_t;

    // Counter width for an arbitrary WIDTH; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/udivider_if.sv
// rtl/udivider_if.sv - start/done handshake and operand/result bus of the divider
//   start, in1, in2         : issuer -> divider
//   ready, busy, done       : divider status
//   quot, rem, div0         : divider results
//   Modports: master (issuing control logic), slave (divider)
interface udivider_if
    import udiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div0;

    modport master (
        output start, in1, in2,
        input  ready, busy, done, quot, rem, div0
    );

    modport slave (
        input  start, in1, in2,
        output ready, busy, done, quot, rem, div0
    );

endinterface

// File: rtl/udiv_step.sv
// rtl/udiv_step.sv - one combinational restoring-division step
//   i_p       : current partial remainder (always < i_divisor)
//   i_q_msb   : bit shifted from the dividend register into the remainder
//   i_divisor : divisor
//   o_p_next  : partial remainder after the trial subtraction
//   o_q_bit   : quotient bit produced by this step
module udiv_step
    import udiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_p_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_p, i_q_msb};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // Since i_p < divisor, the shifted value is < 2*divisor: the top bit of
    // the difference is a clean sign, and either candidate fits WIDTH bits.
    assign o_q_bit  = ~w_diff[WIDTH];
    assign o_p_next = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/udivider.sv
// rtl/udivider.sv - unsigned restoring radix-2 sequential divider, one quotient bit per clock
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : udivider_if.slave (start/in1/in2 in; ready/busy/done/quot/rem/div0 out)
//   Macro UDIV_EARLY_OUT_EN: finish in one cycle when in1 < in2 (in2 != 0)
module udivider
    import udiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    udivider_if.slave  bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    udiv_state_t      r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_div0;

    logic [WIDTH-1:0] w_p_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;
    logic             w_early;

    udiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p       (r_p),
        .i_q_msb   (r_q[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_p_next  (w_p_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

`ifdef UDIV_EARLY_OUT_EN
    assign w_early = (bus.in1 < bus.in2);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_divisor <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div0    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_next;
                        r_rem   <= w_p_next;
                        r_div0  <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE accepting gives
                    // back-to-back issue with no dead cycle.
                    if (bus.start) begin
                        r_divisor <= bus.in2;
                        r_p       <= '0;
                        r_q       <= bus.in1;
                        r_cnt     <= '0;
                        if (bus.in2 == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '1;
                            r_rem   <= bus.in1;
                            r_div0  <= 1'b1;
                        end else if (w_early) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_quot  <= '0;
                            r_rem   <= bus.in1;
                            r_div0  <= 1'b0;
                        end else begin
                            r_state <= DIV;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.quot  = r_quot;
    assign bus.rem   = r_rem;
    assign bus.div0  = r_div0;

endmodule

// File: tb/tb_udivider.sv
// tb/tb_udivider.sv - randomized self-checking bench for udivider against an arithmetic model
module tb_udivider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    udivider_if #(.WIDTH(W)) bus ();

    udivider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: done latency in cycles after the accepting edge (0 = the cycle right after it).
    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) return 0;
`ifdef UDIV_EARLY_OUT_EN
        if (a < b) return 0;
`endif
        return W;
    endfunction

    function automatic logic [W-1:0] model_quot(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] model_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Issue one request and capture the result; lat = -1 means done never came.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int busy_cycles);
        @(negedge clk);
        bus.in1 = a;
        bus.in2 = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in1 = $urandom;
        bus.in2 = $urandom;
        lat = -1;
        busy_cycles = 0;
        q = '0;
        r = '0;
        z = 1'b0;
        for (int k = 0; k < W + 8; k++) begin
            if (bus.done) begin
                lat = k;
                q = bus.quot;
                r = bus.rem;
                z = bus.div0;
                break;
            end
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({bus.ready, bus.busy, bus.done, bus.div0} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=1000", {bus.ready, bus.busy, bus.done, bus.div0});
        end
        vectors++;
        if (bus.quot !== '0 || bus.rem !== '0) begin
            miscompares++;
            $display("FAIL reset_results quot=%h rem=%h want 0/0", bus.quot, bus.rem);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        run_op(100, 7, lat, q, r, z, bc);
        vectors++;
        if (lat !== W) begin miscompares++; $display("FAIL basic_latency got=%0d want=%0d", lat, W); end
        vectors++;
        if (q !== 14 || r !== 2 || z !== 1'b0) begin
            miscompares++; $display("FAIL basic_result got=%0d/%0d/%b want=14/2/0", q, r, z);
        end
        vectors++;
        if (bc !== W) begin miscompares++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, W); end
    endtask

    task automatic test_div0();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        run_op(5, 0, lat, q, r, z, bc);
        vectors++;
        if (lat !== 0) begin miscompares++; $display("FAIL div0_latency got=%0d want=0", lat); end
        vectors++;
        if (q !== 32'hFFFF_FFFF || r !== 5 || z !== 1'b1) begin
            miscompares++; $display("FAIL div0_result got=%h/%0d/%b want=ffffffff/5/1", q, r, z);
        end
        vectors++;
        if (bc !== 0) begin miscompares++; $display("FAIL div0_busy got=%0d want=0", bc); end
    endtask

    task automatic test_extremes();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        run_op(32'hFFFF_FFFF, 1, lat, q, r, z, bc);
        vectors++;
        if (lat !== W || q !== 32'hFFFF_FFFF || r !== 0 || z !== 1'b0) begin
            miscompares++; $display("FAIL max_by_one got=%h/%h/%b lat=%0d want=ffffffff/0/0 lat=%0d", q, r, z, lat, W);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, q, r, z, bc);
        vectors++;
        if (lat !== W || q !== 1 || r !== 0 || z !== 1'b0) begin
            miscompares++; $display("FAIL max_by_max got=%h/%h/%b lat=%0d want=1/0/0 lat=%0d", q, r, z, lat, W);
        end
        run_op(0, 13, lat, q, r, z, bc);
        vectors++;
        if (lat !== model_lat(0, 13) || q !== 0 || r !== 0) begin
            miscompares++; $display("FAIL zero_dividend got=%h/%h lat=%0d want=0/0 lat=%0d", q, r, lat, model_lat(0, 13));
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        int seen;
        @(negedge clk);
        bus.in1 = 100;
        bus.in2 = 7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 9; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.ready, bus.busy, bus.done, bus.div0} !== 4'b1000 || bus.quot !== '0 || bus.rem !== '0) begin
            miscompares++;
            $display("FAIL abort_reset_state flags=%b quot=%h rem=%h want flags=1000 0/0",
                     {bus.ready, bus.busy, bus.done, bus.div0}, bus.quot, bus.rem);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d done pulses want=0", seen); end
        run_op(9, 3, lat, q, r, z, bc);
        vectors++;
        if (lat !== W || q !== 3 || r !== 0 || z !== 1'b0) begin
            miscompares++; $display("FAIL abort_then_op got=%0d/%0d/%b lat=%0d want=3/0/0 lat=%0d", q, r, z, lat, W);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic [W-1:0] q1, r1, q2, r2;
        logic rdy;
        @(negedge clk);
        bus.in1 = 50;
        bus.in2 = 6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.in1 = 7;
        bus.in2 = 2;
        lat1 = -1;
        q1 = '0; r1 = '0; rdy = 1'b0;
        for (int k = 0; k < W + 8; k++) begin
            if (bus.done) begin lat1 = k; q1 = bus.quot; r1 = bus.rem; rdy = bus.ready; break; end
            @(negedge clk);
        end
        vectors++;
        if (lat1 !== W || q1 !== 8 || r1 !== 2 || rdy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_first got=%0d/%0d ready=%b lat=%0d want=8/2 ready=1 lat=%0d", q1, r1, rdy, lat1, W);
        end
        @(negedge clk);
        lat2 = -1;
        q2 = '0; r2 = '0;
        for (int k = 0; k < W + 8; k++) begin
            if (bus.done) begin lat2 = k; q2 = bus.quot; r2 = bus.rem; bus.start = 1'b0; break; end
            @(negedge clk);
        end
        bus.start = 1'b0;
        vectors++;
        if (lat2 !== W || q2 !== 3 || r2 !== 1) begin
            miscompares++; $display("FAIL b2b_second got=%0d/%0d lat=%0d want=3/1 lat=%0d", q2, r2, lat2, W);
        end
    endtask

    task automatic test_early_out();
        int lat, bc;
        logic [W-1:0] q, r;
        logic z;
        run_op(3, 10, lat, q, r, z, bc);
        vectors++;
        if (lat !== model_lat(3, 10) || q !== 0 || r !== 3 || z !== 1'b0) begin
            miscompares++; $display("FAIL early_out got=%0d/%0d/%b lat=%0d want=0/3/0 lat=%0d", q, r, z, lat, model_lat(3, 10));
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [W-1:0] a, b, q, r;
        logic z;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = W'($urandom_range(0, 15));
                2: begin b = $urandom; a = W'($urandom_range(0, 255)); end
                3: b = a >> $urandom_range(0, 31);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(a, b, lat, q, r, z, bc);
            vectors++;
            if (lat !== model_lat(a, b) || q !== model_quot(a, b) || r !== model_rem(a, b) || z !== (b == 0)) begin
                miscompares++;
                $display("FAIL random a=%h b=%h got=%h/%h/%b lat=%0d want=%h/%h/%b lat=%0d",
                         a, b, q, r, z, lat, model_quot(a, b), model_rem(a, b), (b == 0), model_lat(a, b));
            end else if (b != 0) begin
                vectors++;
                if (64'(q) * 64'(b) + 64'(r) !== 64'(a) || !(r < b)) begin
                    miscompares++; $display("FAIL invariant a=%h b=%h quot=%h rem=%h", a, b, q, r);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_div0();
        test_extremes();
        test_reset_abort();
        test_back_to_back();
        test_early_out();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
